// File: rtl/alu_wb_stage.sv
// Two-entry in-order writeback FIFO for ALU results, with a saturating retire counter.
// Optional cumulative flag OR is compiled in with macro ALU_WB_STICKY_FLAGS_EN.
module alu_wb_stage #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic [3:0]        in_flags,
    input  logic [1:0]        in_op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [3:0]        out_flags,
    output logic [1:0]        out_op,
    output logic [1:0]        level,
    output logic [7:0]        retired,
    input  logic              sticky_clr,
    output logic [3:0]        sticky_flags
);

    // state | meaning
    // EMPTY | no entries held, head fields forced to zero
    // ONE   | head entry (slot 0) valid
    // FULL  | slot 0 is head, slot 1 is next; upstream stalled
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] res0, res1;
    logic [3:0]        flg0, flg1;
    logic [1:0]        op0, op1;
    logic              push, pop;

    // in_ready looks only at occupancy and reset, never at out_ready
    assign in_ready  = (state != FULL) && !rst;
    assign out_valid = (state != EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign out_result = out_valid ? res0 : '0;
    assign out_flags  = out_valid ? flg0 : 4'h0;
    assign out_op     = out_valid ? op0  : 2'h0;
    assign level      = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            res0  <= '0;
            res1  <= '0;
            flg0  <= 4'h0;
            flg1  <= 4'h0;
            op0   <= 2'h0;
            op1   <= 2'h0;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        res0  <= in_result;
                        flg0  <= in_flags;
                        op0   <= in_op;
                        state <= ONE;
                    end
                end
                ONE: begin
                    case ({push, pop})
                        2'b10: begin
                            res1  <= in_result;
                            flg1  <= in_flags;
                            op1   <= in_op;
                            state <= FULL;
                        end
                        2'b01: state <= EMPTY;
                        // Head leaves and the new entry takes its place
                        2'b11: begin
                            res0 <= in_result;
                            flg0 <= in_flags;
                            op0  <= in_op;
                        end
                        default: state <= ONE;
                    endcase
                end
                FULL: begin
                    if (pop) begin
                        res0  <= res1;
                        flg0  <= flg1;
                        op0   <= op1;
                        state <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            retired <= 8'h00;
        end else if (pop && (retired != 8'hFF)) begin
            retired <= retired + 8'd1;
        end
    end

`ifdef ALU_WB_STICKY_FLAGS_EN
    // A clear coinciding with a push leaves exactly the new flags
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_flags <= 4'h0;
        end else if (sticky_clr) begin
            sticky_flags <= push ? in_flags : 4'h0;
        end else if (push) begin
            sticky_flags <= sticky_flags | in_flags;
        end
    end
`else
    logic sticky_clr_unused;
    assign sticky_clr_unused = sticky_clr;
    assign sticky_flags      = 4'h0;
`endif

endmodule

// File: doc/alu_wb_stage.md
ALU_WB_STAGE -- requirements
Module: alu_wb_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of ALU result path.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  upstream ALU result valid.
REQ-005 SHALL have port in_ready  output  1  stage can accept a result this cycle.
REQ-006 SHALL have port in_result  input  DATA_W  ALU result.
REQ-007 SHALL have port in_flags  input  4  ALU flags {carry, overflow, zero, sign}, bit 3 down to bit 0.
REQ-008 SHALL have port in_op  input  2  alu_op that produced the result.
REQ-009 SHALL have port out_valid  output  1  head entry valid to consumer.
REQ-010 SHALL have port out_ready  input  1  consumer accepts head entry.
REQ-011 SHALL have ports out_result (DATA_W), out_flags (4), out_op (2)  outputs  head entry fields.
REQ-012 SHALL have port level  output  2  current occupancy, 0..2.
REQ-013 SHALL have port retired  output  8  saturating count of entries popped.
REQ-014 SHALL have ports sticky_clr (input, 1) and sticky_flags (output, 4)  cumulative flag OR.

Function
REQ-015 SHALL be a 2-entry in-order FIFO with states EMPTY (level 0), ONE (level 1), FULL (level 2).
REQ-016 SHALL define push = in_valid & in_ready and pop = out_valid & out_ready.
REQ-017 SHALL drive in_ready = 1 in EMPTY and ONE, 0 in FULL; in_ready SHALL NOT depend on out_ready.
REQ-018 SHALL drive out_valid = 1 in ONE and FULL, 0 in EMPTY; no combinational bypass, so minimum latency is 1 cycle from push to out_valid.
REQ-019 SHALL transition: EMPTY-push->ONE; ONE-push&!pop->FULL; ONE-pop&!push->EMPTY; ONE-push&pop->ONE; FULL-pop->ONE; all other cases hold state.
REQ-020 SHALL, on ONE with simultaneous push and pop, present the newly pushed entry at the head next cycle.
REQ-021 SHALL hold out_result/out_flags/out_op stable while out_valid=1 and out_ready=0.
REQ-022 SHALL ignore in_* data when push=0; upstream data SHALL NOT reach outputs without a push.
REQ-023 SHALL drive out_result/out_flags/out_op to 0 when state is EMPTY.
REQ-024 SHALL increment retired by 1 on each pop and saturate at 8'hFF.
REQ-025 SHALL drive level equal to the state encoding (EMPTY=0, ONE=1, FULL=2); value 3 SHALL never occur.

Reset
REQ-026 SHALL, when rst=1 at a clock edge, enter EMPTY and clear retired, sticky_flags and all entry storage, regardless of in-flight handshakes.
REQ-027 SHALL drive in_ready=0 during any cycle with rst=1 and in_ready=1 the first cycle after rst deasserts.
REQ-028 SHALL discard a push or pop coincident with rst=1 (no count, no sticky update).

Configuration
REQ-029 SHALL use macro ALU_WB_STICKY_FLAGS_EN to compile the sticky-flag feature in or out.
REQ-030 SHALL, with ALU_WB_STICKY_FLAGS_EN defined, set sticky_flags |= in_flags on each push; sticky_clr=1 clears it; on sticky_clr with push in the same cycle the result is exactly in_flags.
REQ-031 SHALL, without ALU_WB_STICKY_FLAGS_EN, keep both ports, drive sticky_flags to 4'h0 constantly and ignore sticky_clr.

Verification
REQ-032 SHALL cover: reset, push result 8'h3C flags 4'b0010 op 2'b01 with out_ready=0 -> out_valid=1 next cycle, outputs hold 8'h3C/4'b0010/2'b01 until out_ready=1, then level returns to 0 and retired=1.
REQ-033 SHALL cover: three back-to-back pushes 8'h01, 8'h02, 8'h03 with out_ready=0 -> level=2, in_ready=0 after second push, third not accepted; draining yields 8'h01 then 8'h02.
REQ-034 SHALL cover: level=1 holding 8'hAA, push 8'h55 with out_ready=1 -> level stays 1, head becomes 8'h55 next cycle.
REQ-035 SHALL cover: 300 pops with continuous push/pop -> retired saturates at 8'hFF.
REQ-036 SHALL cover (macro defined): push flags 4'b1000 then 4'b0001 -> sticky_flags=4'b1001; sticky_clr with push of 4'b0100 -> 4'b0100; without the macro sticky_flags stays 4'h0.
REQ-037 SHALL cover: rst asserted while level=2 and out_ready=1 -> next cycle level=0, out_valid=0, retired unchanged from 0 after the reset clear.
